blink_detector: RTL and testbench

Front-end conditioner for the IR receiver path. It synchronises the raw photodiode comparator output, debounces it, and qualifies each high pulse by width. It emits a single-cycle `blinky` strobe per valid blink, which the downstream decision counter consumes directly. Glitches, short pulses and (optionally) stuck-high inputs are flagged instead of being forwarded.

---
 rtl/blink_detector.sv | 163 ++++++++++++++++
 tb/tb_blink_detector.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/blink_detector.sv
// rtl/blink_detector.sv - IR blink detector: synchroniser, debounce, pulse-width qualification
//
// Optional feature macro: BLINK_TIMEOUT_EN (adds the STUCK state and the stuck output).
//
// Ports:
//   clock        in  1  single clock
//   reset        in  1  asynchronous active-high reset, clears every flop
//   sensor_raw   in  1  asynchronous raw IR comparator output
//   blinky       out 1  one-cycle strobe per valid blink
//   blink_width  out W  on-time of the last valid blink, loaded with blinky
//   reject       out 1  one-cycle strobe for a blink shorter than MIN_ON_CYCLES
//   stuck        out 1  high while the input is held stuck (0 without BLINK_TIMEOUT_EN)
module blink_detector #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int MIN_ON_CYCLES   = 50000,
    parameter int MAX_ON_CYCLES   = 5000000,
    parameter int W               = $clog2(MAX_ON_CYCLES + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         sensor_raw,
    output logic         blinky,
    output logic [W-1:0] blink_width,
    output logic         reject,
    output logic         stuck
);

    // dcnt only ever holds 0..DEBOUNCE_CYCLES-1
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [W-1:0]  MIN_ON   = W'(MIN_ON_CYCLES);
    localparam logic [W-1:0]  OCNT_SAT = '1;
`ifdef BLINK_TIMEOUT_EN
    localparam logic [W-1:0]  MAX_ON   = W'(MAX_ON_CYCLES);
`endif

`ifdef BLINK_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, ON, STUCK} state_t;
`else
    typedef enum logic [0:0] {IDLE, ON} state_t;
`endif

    logic          s1, s2;
    logic          acc;
    logic [DW-1:0] dcnt;

    state_t        state, state_nx;
    logic [W-1:0]  ocnt, ocnt_nx;
    logic [W-1:0]  width_nx;
    logic          blinky_nx, reject_nx;
`ifdef BLINK_TIMEOUT_EN
    logic          stuck_nx;
`endif

    // Two-flop synchroniser followed by a counter debounce: acc only follows
    // s2 after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            acc  <= 1'b0;
            dcnt <= '0;
        end else begin
            s1 <= sensor_raw;
            s2 <= s1;
            if (s2 == acc) begin
                dcnt <= '0;
            end else if (dcnt == DEB_LAST) begin
                acc  <= ~acc;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ocnt        <= '0;
            blink_width <= '0;
            blinky      <= 1'b0;
            reject      <= 1'b0;
        end else begin
            state       <= state_nx;
            ocnt        <= ocnt_nx;
            blink_width <= width_nx;
            blinky      <= blinky_nx;
            reject      <= reject_nx;
        end
    end

`ifdef BLINK_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stuck <= 1'b0;
        end else begin
            stuck <= stuck_nx;
        end
    end
`else
    assign stuck = 1'b0;
`endif

    // Strobes are computed here and registered, so they appear the cycle
    // after acc falls. The first high cycle of acc is counted on entry to ON.
    always_comb begin
        state_nx  = state;
        ocnt_nx   = ocnt;
        width_nx  = blink_width;
        blinky_nx = 1'b0;
        reject_nx = 1'b0;
`ifdef BLINK_TIMEOUT_EN
        stuck_nx  = 1'b0;
`endif
        case (state)
            IDLE: begin
                ocnt_nx = '0;
                if (acc) begin
                    state_nx = ON;
                    ocnt_nx  = W'(1);
                end
            end
            ON: begin
                if (!acc) begin
                    state_nx = IDLE;
                    ocnt_nx  = '0;
                    if (ocnt >= MIN_ON) begin
                        blinky_nx = 1'b1;
                        width_nx  = ocnt;
                    end else begin
                        reject_nx = 1'b1;
                    end
                end
`ifdef BLINK_TIMEOUT_EN
                else if (ocnt >= MAX_ON) begin
                    state_nx = STUCK;
                    stuck_nx = 1'b1;
                end
`endif
                else if (ocnt != OCNT_SAT) begin
                    ocnt_nx = ocnt + 1'b1;
                end
            end
`ifdef BLINK_TIMEOUT_EN
            STUCK: begin
                // leave silently once the input finally drops
                if (!acc) begin
                    state_nx = IDLE;
                    ocnt_nx  = '0;
                end else begin
                    stuck_nx = 1'b1;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
                ocnt_nx  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_blink_detector.sv
// tb/tb_blink_detector.sv - directed scoreboard bench for blink_detector
module tb_blink_detector;

    logic       clock;
    logic       reset;
    logic       sensor_raw;
    logic       blinky;
    logic [5:0] blink_width;
    logic       reject;
    logic       stuck;

    blink_detector #(
        .DEBOUNCE_CYCLES(4),
        .MIN_ON_CYCLES  (10),
        .MAX_ON_CYCLES  (50),
        .W              (6)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sensor_raw (sensor_raw),
        .blinky     (blinky),
        .blink_width(blink_width),
        .reject     (reject),
        .stuck      (stuck)
    );

    typedef struct {
        bit         is_reject;
        logic [5:0] width;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic [5:0] last_width = '0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Strobe expected on the 7th edge counting the one that first samples the fall.
    task automatic push_exp(input bit is_rej, input logic [5:0] w);
        exp_t e;
        e.is_reject = is_rej;
        e.width     = w;
        e.cyc       = cyc + 7;
        q.push_back(e);
    endtask

    task automatic check_stuck(input string tag, input logic exp);
        checks++;
        assert (stuck === exp) else begin
            errors++;
            $error("FAIL %s: stuck=%0b expected=%0b", tag, stuck, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && (blinky || reject)) begin
            checks++;
            assert (!(blinky && reject)) else begin
                errors++;
                $error("FAIL exclusive: blinky=%0b reject=%0b expected only one", blinky, reject);
            end
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_strobe: blinky=%0b reject=%0b at cycle %0d expected none", blinky, reject, cyc);
            end
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                assert (reject === e.is_reject) else begin
                    errors++;
                    $error("FAIL kind: reject=%0b expected=%0b", reject, e.is_reject);
                end
                checks++;
                assert (blink_width === e.width) else begin
                    errors++;
                    $error("FAIL width: blink_width=%0d expected=%0d", blink_width, e.width);
                end
                checks++;
                assert (cyc === e.cyc) else begin
                    errors++;
                    $error("FAIL timing: strobe cycle=%0d expected=%0d", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        logic acc_seen;
        int   c;
        reset      = 1'b1;
        sensor_raw = 1'b0;
        tick(3);
        checks++;
        assert ({blinky, reject, stuck, blink_width} === 9'd0) else begin
            errors++;
            $error("FAIL reset_state: outputs=%0h expected=0", {blinky, reject, stuck, blink_width});
        end
        reset = 1'b0;
        tick(100);

        // valid blink
        sensor_raw = 1'b1;
        tick(20);
        sensor_raw = 1'b0;
        push_exp(1'b0, 6'd20);
        last_width = 6'd20;
        tick(15);

        // glitch: acc must never rise
        acc_seen   = 1'b0;
        sensor_raw = 1'b1;
        tick(3);
        sensor_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            acc_seen = acc_seen | dut.acc;
        end
        checks++;
        assert (acc_seen === 1'b0) else begin
            errors++;
            $error("FAIL glitch_acc: acc_seen=%0b expected=0", acc_seen);
        end

        // short pulse, width keeps last valid value
        sensor_raw = 1'b1;
        tick(8);
        sensor_raw = 1'b0;
        push_exp(1'b1, last_width);
        tick(15);

        // asynchronous reset mid-cycle clears outputs at once
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        assert ({blinky, reject, stuck, blink_width} === 9'd0) else begin
            errors++;
            $error("FAIL async_reset: outputs=%0h expected=0", {blinky, reject, stuck, blink_width});
        end
        last_width = '0;
        tick(2);
        reset = 1'b0;
        tick(10);

        // 80-cycle stuck-high input
        c = cyc;
        sensor_raw = 1'b1;
        tick(56);
        check_stuck("stuck_before", 1'b0);
        tick(1);
`ifdef BLINK_TIMEOUT_EN
        check_stuck("stuck_rise", 1'b1);
`else
        check_stuck("stuck_rise", 1'b0);
`endif
        tick(80 - (cyc - c));
        sensor_raw = 1'b0;
`ifndef BLINK_TIMEOUT_EN
        push_exp(1'b0, 6'd63);
        last_width = 6'd63;
`endif
        tick(6);
`ifdef BLINK_TIMEOUT_EN
        check_stuck("stuck_hold", 1'b1);
`else
        check_stuck("stuck_hold", 1'b0);
`endif
        tick(1);
        check_stuck("stuck_clear", 1'b0);
        tick(15);

        // back-to-back blinks
        sensor_raw = 1'b1;
        tick(15);
        sensor_raw = 1'b0;
        push_exp(1'b0, 6'd15);
        tick(5);
        sensor_raw = 1'b1;
        tick(15);
        sensor_raw = 1'b0;
        push_exp(1'b0, 6'd15);
        last_width = 6'd15;
        tick(15);

        // third blink aborted by reset
        sensor_raw = 1'b1;
        tick(10);
        @(posedge clock);
        #3;
        reset      = 1'b1;
        sensor_raw = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(30);
        checks++;
        assert (blink_width === 6'd0) else begin
            errors++;
            $error("FAIL abort_width: blink_width=%0d expected=0", blink_width);
        end
        checks++;
        assert (q.size() === 0) else begin
            errors++;
            $error("FAIL missing_strobes: pending=%0d expected=0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
